// File: rtl/debug_unit.sv
// Debug unit: a byte-oriented command monitor that sits between a serial
// link and a small accumulator CPU. It loads program memory from the host,
// resets and runs the CPU until it halts or the host aborts, single-steps it,
// and reports PC, accumulator and cycle counter back over the link.
module debug_unit #(
    parameter int NB_INSTRUC = 16,
    parameter int NB_OPCODE  = 5,
    parameter int NB_ADDR    = 11,
    parameter int NB_DATA    = 16,
    parameter int NB_BYTE    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NB_BYTE-1:0]    i_rx_data,
    input  logic                  i_rx_valid,
    output logic [NB_BYTE-1:0]    o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done,
    output logic                  o_prog_we,
    output logic [NB_ADDR-1:0]    o_prog_addr,
    output logic [NB_INSTRUC-1:0] o_prog_data,
    input  logic [NB_INSTRUC-1:0] i_instruc,
    input  logic [NB_ADDR-1:0]    i_cpu_pc,
    input  logic [NB_DATA-1:0]    i_cpu_acc,
    output logic                  o_cpu_en,
    output logic                  o_cpu_rst_n,
    output logic [2:0]            o_state
);

    localparam logic [NB_BYTE-1:0] CMD_LOAD  = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_RUN   = NB_BYTE'(8'h52);
    localparam logic [NB_BYTE-1:0] CMD_STEP  = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_ABORT = NB_BYTE'(8'h41);
    localparam logic [NB_ADDR-1:0] ADDR_LAST = '1;
    localparam logic [15:0]        CNT_MAX   = 16'hFFFF;
    localparam logic [2:0]         LAST_BYTE = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_HI = 3'd1,
        ST_LOAD_LO = 3'd2,
        ST_CPU_RST = 3'd3,
        ST_RUN     = 3'd4,
        ST_STEP    = 3'd5,
        ST_SEND    = 3'd6
    } state_t;

    state_t state, state_next;

    logic [NB_ADDR-1:0]    load_addr;
    logic [NB_BYTE-1:0]    hi_byte;
    logic [15:0]           cycle_cnt;
    logic [15:0]           cnt_inc;
    logic [15:0]           snap_pc;
    logic [15:0]           snap_acc;
    logic [15:0]           snap_cnt;
    logic                  snap_pending;
    logic                  tx_busy;
    logic [2:0]            tx_idx;
    logic [NB_BYTE-1:0]    tx_byte;
    logic [NB_BYTE-1:0]    tx_data_q;
    logic                  tx_start_q;
    logic [NB_INSTRUC-1:0] load_word;
    logic                  load_halt;
    logic                  load_last;
    logic                  halt_op;
    logic                  abort_cmd;
    logic                  unused_instr_bits;

    assign halt_op           = (i_instruc[NB_INSTRUC-1 -: NB_OPCODE] == '0);
    assign abort_cmd         = i_rx_valid && (i_rx_data == CMD_ABORT);
    assign load_word         = NB_INSTRUC'({hi_byte, i_rx_data});
    assign load_halt         = (load_word[NB_INSTRUC-1 -: NB_OPCODE] == '0);
    assign load_last         = (load_addr == ADDR_LAST);
    assign cnt_inc           = (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + 16'd1;
    assign unused_instr_bits = ^i_instruc[NB_INSTRUC-NB_OPCODE-1:0];

    assign o_cpu_rst_n = i_rst && (state != ST_CPU_RST);
    assign o_prog_addr = load_addr;
    assign o_prog_data = o_prog_we ? load_word : '0;
    assign o_tx_data   = tx_data_q;
    assign o_tx_start  = tx_start_q;
    assign o_state     = state;

    // State register; reset drops straight back to IDLE from anywhere.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state decode plus the combinational CPU enable and write strobe,
    // so a HALT or abort gates the CPU in the very cycle it is seen.
    always_comb begin
        state_next = state;
        o_cpu_en   = 1'b0;
        o_prog_we  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD)      state_next = ST_LOAD_HI;
                    else if (i_rx_data == CMD_RUN)  state_next = ST_CPU_RST;
                    else if (i_rx_data == CMD_STEP) state_next = ST_STEP;
                end
            end
            ST_LOAD_HI: begin
                if (i_rx_valid) state_next = ST_LOAD_LO;
            end
            ST_LOAD_LO: begin
                if (i_rx_valid) begin
                    o_prog_we  = 1'b1;
                    state_next = (load_halt || load_last) ? ST_IDLE : ST_LOAD_HI;
                end
            end
            ST_CPU_RST: state_next = ST_RUN;
            ST_RUN: begin
                if (halt_op || abort_cmd) state_next = ST_SEND;
                else                      o_cpu_en   = 1'b1;
            end
            ST_STEP: begin
                o_cpu_en   = 1'b1;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (!snap_pending && tx_busy && i_tx_done && (tx_idx == LAST_BYTE))
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Picks the report byte for the current position: PC, ACC, CNT, high first.
    always_comb begin
        tx_byte = '0;
        case (tx_idx)
            3'd0:    tx_byte = NB_BYTE'(snap_pc[15:8]);
            3'd1:    tx_byte = NB_BYTE'(snap_pc[7:0]);
            3'd2:    tx_byte = NB_BYTE'(snap_acc[15:8]);
            3'd3:    tx_byte = NB_BYTE'(snap_acc[7:0]);
            3'd4:    tx_byte = NB_BYTE'(snap_cnt[15:8]);
            3'd5:    tx_byte = NB_BYTE'(snap_cnt[7:0]);
            default: tx_byte = '0;
        endcase
    end

    // Datapath: load address/high byte, cycle counter, snapshot and the
    // transmit sequencer that waits for each byte's done strobe.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            load_addr    <= '0;
            hi_byte      <= '0;
            cycle_cnt    <= '0;
            snap_pc      <= '0;
            snap_acc     <= '0;
            snap_cnt     <= '0;
            snap_pending <= 1'b0;
            tx_busy      <= 1'b0;
            tx_idx       <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_rx_valid && (i_rx_data == CMD_LOAD)) load_addr <= '0;
                end
                ST_LOAD_HI: begin
                    if (i_rx_valid) hi_byte <= i_rx_data;
                end
                ST_LOAD_LO: begin
                    if (i_rx_valid)
                        load_addr <= (load_halt || load_last) ? '0 : load_addr + NB_ADDR'(1);
                end
                ST_CPU_RST: cycle_cnt <= '0;
                ST_RUN: begin
                    if (o_cpu_en) begin
                        cycle_cnt <= cnt_inc;
                    end else begin
                        snap_pc      <= 16'(i_cpu_pc);
                        snap_acc     <= 16'(i_cpu_acc);
                        snap_cnt     <= cycle_cnt;
                        snap_pending <= 1'b0;
                        tx_busy      <= 1'b0;
                        tx_idx       <= '0;
                    end
                end
                ST_STEP: begin
                    cycle_cnt    <= cnt_inc;
                    snap_pending <= 1'b1;
                    tx_busy      <= 1'b0;
                    tx_idx       <= '0;
                end
                ST_SEND: begin
                    if (snap_pending) begin
                        snap_pc      <= 16'(i_cpu_pc);
                        snap_acc     <= 16'(i_cpu_acc);
                        snap_cnt     <= cycle_cnt;
                        snap_pending <= 1'b0;
                    end else if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= tx_byte;
                        tx_busy    <= 1'b1;
                    end else if (i_tx_done) begin
                        tx_busy <= 1'b0;
                        tx_idx  <= (tx_idx == LAST_BYTE) ? 3'd0 : tx_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_unit.sv
// Testbench for debug_unit: emulates a tiny accumulator CPU and a UART
// transmitter around the DUT, predicts program writes and report bytes from
// the command semantics, and checks the per-cycle output rules every cycle.
module tb_debug_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic        o_prog_we;
    logic [10:0] o_prog_addr;
    logic [15:0] o_prog_data;
    logic [15:0] i_instruc;
    logic [10:0] i_cpu_pc;
    logic [15:0] i_cpu_acc;
    logic        o_cpu_en;
    logic        o_cpu_rst_n;
    logic [2:0]  o_state;

    int total = 0;
    int bad   = 0;
    int wr_count = 0;
    int starts_seen = 0;
    int dones_given = 0;
    int rst_low_cycles = 0;
    int en_seen = 0;
    int got_n = 0;
    bit hold_done = 1'b0;

    logic [10:0] exp_addr_q[$];
    logic [15:0] exp_data_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [7:0]  got_tx[0:5];
    logic [15:0] m_pc, m_acc, m_cnt;

    logic [15:0] prog[0:63];
    logic [10:0] cpu_pc;
    logic [15:0] cpu_acc;

    always #5 i_clk = ~i_clk;

    debug_unit dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .i_tx_done  (i_tx_done),
        .o_prog_we  (o_prog_we),
        .o_prog_addr(o_prog_addr),
        .o_prog_data(o_prog_data),
        .i_instruc  (i_instruc),
        .i_cpu_pc   (i_cpu_pc),
        .i_cpu_acc  (i_cpu_acc),
        .o_cpu_en   (o_cpu_en),
        .o_cpu_rst_n(o_cpu_rst_n),
        .o_state    (o_state)
    );

    // Toy CPU: each enabled cycle adds the 11-bit operand to ACC and advances PC.
    always @(posedge i_clk) begin
        if (!o_cpu_rst_n) begin
            cpu_pc  <= '0;
            cpu_acc <= '0;
        end else if (o_cpu_en) begin
            cpu_pc  <= cpu_pc + 11'd1;
            cpu_acc <= cpu_acc + {5'd0, prog[cpu_pc[5:0]][10:0]};
        end
    end

    assign i_instruc = prog[cpu_pc[5:0]];
    assign i_cpu_pc  = cpu_pc;
    assign i_cpu_acc = cpu_acc;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task applyStimulus(input logic [7:0] b);
        @(posedge i_clk);
        #1;
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(posedge i_clk);
        #1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (o_state != 3'd0 && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        checkOutput(name, 32'(o_state), 32'd0);
    endtask

    task automatic wait_start(input int s0, input string name);
        int n = 0;
        while (starts_seen == s0 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        checkOutput(name, 32'(starts_seen - s0), 32'd1);
    endtask

    task automatic push_tx(input logic [15:0] pc, input logic [15:0] acc, input logic [15:0] cnt);
        exp_tx_q.push_back(pc[15:8]);
        exp_tx_q.push_back(pc[7:0]);
        exp_tx_q.push_back(acc[15:8]);
        exp_tx_q.push_back(acc[7:0]);
        exp_tx_q.push_back(cnt[15:8]);
        exp_tx_q.push_back(cnt[7:0]);
        got_n = 0;
    endtask

    task automatic check_tx_literal(input string name, input logic [47:0] exp);
        checkOutput({name, "_count"}, 32'(got_n), 32'd6);
        checkOutput({name, "_pending"}, 32'(exp_tx_q.size()), 32'd0);
        for (int i = 0; i < 6; i++)
            checkOutput(name, 32'(got_tx[i]), 32'(exp[47-8*i -: 8]));
    endtask

    // Run from a fresh CPU reset: everything before the first HALT executes.
    task automatic model_run();
        int i = 0;
        logic [15:0] acc = 16'd0;
        while (i < 64 && prog[i][15:11] != 5'd0) begin
            acc = acc + {5'd0, prog[i][10:0]};
            i++;
        end
        m_pc  = 16'(i);
        m_acc = acc;
        m_cnt = 16'(i);
    endtask

    task automatic model_abort(input int n);
        logic [15:0] acc = 16'd0;
        for (int i = 0; i < n; i++) acc = acc + {5'd0, prog[i][10:0]};
        m_pc  = 16'(n);
        m_acc = acc;
        m_cnt = 16'(n);
    endtask

    task automatic model_step();
        m_acc = m_acc + {5'd0, prog[m_pc[5:0]][10:0]};
        m_pc  = m_pc + 16'd1;
        m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
    endtask

    task do_reset();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        exp_tx_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
        m_pc  = 16'd0;
        m_acc = 16'd0;
        m_cnt = 16'd0;
        i_rx_valid = 1'b0;
        i_rst = 1'b1;
    endtask

    // Per-cycle checker: reset values, enable/strobe rules, write and tx scoreboards.
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                checkOutput("rst_state",     32'(o_state),     32'd0);
                checkOutput("rst_cpu_rst_n", 32'(o_cpu_rst_n), 32'd0);
                checkOutput("rst_cpu_en",    32'(o_cpu_en),    32'd0);
                checkOutput("rst_prog_we",   32'(o_prog_we),   32'd0);
                checkOutput("rst_tx_start",  32'(o_tx_start),  32'd0);
                checkOutput("rst_tx_data",   32'(o_tx_data),   32'd0);
                checkOutput("rst_prog_addr", 32'(o_prog_addr), 32'd0);
                checkOutput("rst_prog_data", 32'(o_prog_data), 32'd0);
            end else begin
                if (o_state inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd6})
                    checkOutput("cpu_en_off", 32'(o_cpu_en), 32'd0);
                if (o_state == 3'd4)
                    checkOutput("run_en", 32'(o_cpu_en),
                                32'((i_instruc[15:11] != 5'd0) && !(i_rx_valid && i_rx_data == 8'h41)));
                if (o_state == 3'd5)
                    checkOutput("step_en", 32'(o_cpu_en), 32'd1);
                checkOutput("cpu_rst_n", 32'(o_cpu_rst_n), (o_state == 3'd3) ? 32'd0 : 32'd1);
                if (o_state != 3'd2)
                    checkOutput("we_off", 32'(o_prog_we), 32'd0);
                if (!o_cpu_rst_n) rst_low_cycles++;
                if (o_cpu_en) en_seen++;
                if (o_prog_we) begin
                    wr_count++;
                    if (exp_addr_q.size() == 0) begin
                        checkOutput("write_unexpected", 32'd1, 32'd0);
                    end else begin
                        checkOutput("write_addr", 32'(o_prog_addr), 32'(exp_addr_q.pop_front()));
                        checkOutput("write_data", 32'(o_prog_data), 32'(exp_data_q.pop_front()));
                    end
                end
                if (o_tx_start) begin
                    starts_seen++;
                    if (exp_tx_q.size() == 0)
                        checkOutput("tx_unexpected", 32'd1, 32'd0);
                    else
                        checkOutput("tx_byte", 32'(o_tx_data), 32'(exp_tx_q.pop_front()));
                    if (got_n < 6) got_tx[got_n] = o_tx_data;
                    got_n++;
                end
            end
        end
    end

    // Transmitter stand-in: answers each start with a done strobe a few cycles later.
    initial begin
        int delay = 2;
        i_tx_done = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            i_tx_done = 1'b0;
            if (!i_rst) begin
                dones_given = starts_seen;
                delay = 2;
            end else if (starts_seen > dones_given && !hold_done) begin
                if (delay == 0) begin
                    i_tx_done = 1'b1;
                    dones_given++;
                    delay = 2;
                end else begin
                    delay--;
                end
            end
        end
    end

    // Watchdog so the bench always ends even if the DUT locks up.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed command sequence.
    initial begin
        int w0, r0, e0, s0, n;
        logic [15:0] word;

        i_rst      = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        for (int i = 0; i < 64; i++) prog[i] = 16'h0801;
        m_pc  = 16'd0;
        m_acc = 16'd0;
        m_cnt = 16'd0;

        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(negedge i_clk);
        checkOutput("release_state", 32'(o_state), 32'd0);
        checkOutput("release_cpu_rst_n", 32'(o_cpu_rst_n), 32'd1);

        $display("[TB] unknown bytes in IDLE");
        applyStimulus(8'h11);
        applyStimulus(8'h41);
        @(negedge i_clk);
        checkOutput("idle_ignore", 32'(o_state), 32'd0);

        $display("[TB] short load");
        w0 = wr_count;
        exp_addr_q.push_back(11'h000); exp_data_q.push_back(16'h0805);
        exp_addr_q.push_back(11'h001); exp_data_q.push_back(16'h0000);
        applyStimulus(8'h4C);
        applyStimulus(8'h08);
        applyStimulus(8'h05);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        wait_idle(20, "load_idle");
        checkOutput("load_pulses", 32'(wr_count - w0), 32'd2);
        checkOutput("load_pending", 32'(exp_addr_q.size()), 32'd0);

        $display("[TB] full-memory load with wrap");
        w0 = wr_count;
        applyStimulus(8'h4C);
        for (int a = 0; a < 2048; a++) begin
            word = 16'h0800 | 16'(a);
            exp_addr_q.push_back(11'(a));
            exp_data_q.push_back(word);
            applyStimulus(word[15:8]);
            applyStimulus(word[7:0]);
        end
        wait_idle(20, "wrap_idle");
        checkOutput("wrap_pulses", 32'(wr_count - w0), 32'd2048);
        exp_addr_q.push_back(11'h000); exp_data_q.push_back(16'h0000);
        applyStimulus(8'h4C);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        wait_idle(20, "wrap_reload_idle");
        checkOutput("wrap_pending", 32'(exp_addr_q.size()), 32'd0);

        $display("[TB] run to HALT");
        prog[0] = 16'h0FFF;
        prog[1] = 16'h0FFF;
        prog[2] = 16'h0A36;
        prog[3] = 16'h0000;
        prog[4] = 16'h0801;
        r0 = rst_low_cycles;
        e0 = en_seen;
        model_run();
        push_tx(m_pc, m_acc, m_cnt);
        applyStimulus(8'h52);
        wait_idle(200, "run_idle");
        checkOutput("run_rst_cycles", 32'(rst_low_cycles - r0), 32'd1);
        checkOutput("run_en_cycles", 32'(en_seen - e0), 32'd3);
        check_tx_literal("run_tx", 48'h0003_1234_0003);

        $display("[TB] single step");
        e0 = en_seen;
        model_step();
        push_tx(m_pc, m_acc, m_cnt);
        applyStimulus(8'h53);
        wait_idle(200, "step1_idle");
        checkOutput("step1_en_cycles", 32'(en_seen - e0), 32'd1);
        check_tx_literal("step1_tx", 48'h0004_1234_0004);

        $display("[TB] single step with stalled transmitter");
        hold_done = 1'b1;
        model_step();
        push_tx(m_pc, m_acc, m_cnt);
        s0 = starts_seen;
        applyStimulus(8'h53);
        wait_start(s0, "stall_first_start");
        repeat (20) @(negedge i_clk);
        applyStimulus(8'h4C);
        @(negedge i_clk);
        checkOutput("stall_starts", 32'(starts_seen - s0), 32'd1);
        checkOutput("stall_state", 32'(o_state), 32'd6);
        hold_done = 1'b0;
        wait_idle(200, "step2_idle");
        checkOutput("step2_starts", 32'(starts_seen - s0), 32'd6);
        check_tx_literal("step2_tx", 48'h0005_1235_0005);

        $display("[TB] run aborted by host");
        for (int i = 0; i < 64; i++) prog[i] = 16'h0801;
        e0 = en_seen;
        applyStimulus(8'h52);
        n = 0;
        while ((en_seen - e0) < 10 && n < 100) begin
            @(posedge i_clk);
            #1;
            i_rx_valid = ((en_seen - e0) == 4);
            i_rx_data  = 8'h5A;
            n++;
        end
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h41;
        model_abort(en_seen - e0);
        push_tx(m_pc, m_acc, m_cnt);
        @(negedge i_clk);
        checkOutput("abort_en", 32'(o_cpu_en), 32'd0);
        @(posedge i_clk);
        #1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        wait_idle(200, "abort_idle");
        checkOutput("abort_en_cycles", 32'(en_seen - e0), 32'd10);
        check_tx_literal("abort_tx", 48'h000A_000A_000A);

        $display("[TB] reset in the middle of a load");
        w0 = wr_count;
        applyStimulus(8'h4C);
        applyStimulus(8'h08);
        @(posedge i_clk);
        #1;
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h05;
        i_rst      = 1'b0;
        do_reset();
        repeat (4) @(negedge i_clk);
        checkOutput("load_reset_pulses", 32'(wr_count - w0), 32'd0);
        checkOutput("load_reset_state", 32'(o_state), 32'd0);

        $display("[TB] reset in the middle of a send");
        hold_done = 1'b1;
        model_step();
        push_tx(m_pc, m_acc, m_cnt);
        s0 = starts_seen;
        applyStimulus(8'h53);
        wait_start(s0, "send_reset_first_start");
        do_reset();
        hold_done = 1'b0;
        s0 = starts_seen;
        repeat (10) @(negedge i_clk);
        checkOutput("send_reset_starts", 32'(starts_seen - s0), 32'd0);
        checkOutput("send_reset_state", 32'(o_state), 32'd0);
        checkOutput("send_reset_cpu_rst_n", 32'(o_cpu_rst_n), 32'd1);

        model_step();
        push_tx(m_pc, m_acc, m_cnt);
        applyStimulus(8'h53);
        wait_idle(200, "post_reset_step_idle");
        check_tx_literal("post_reset_step_tx", 48'h0001_0001_0001);

        repeat (3) @(negedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/debug_unit.md
DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 SHALL have parameter NB_INSTRUC, default 16, instruction width.
REQ-002 SHALL have parameter NB_OPCODE, default 5, opcode field width (instruction MSBs).
REQ-003 SHALL have parameter NB_ADDR, default 11, program address width.
REQ-004 SHALL have parameter NB_DATA, default 16, accumulator width.
REQ-005 SHALL have parameter NB_BYTE, default 8, serial byte width.
REQ-006 i_clk  in  1  single clock; all logic is on the rising edge.
REQ-007 i_rst  in  1  reset, asynchronous, active-low.
REQ-008 i_rx_data  in  8  received byte; i_rx_valid  in  1  one-cycle strobe, byte valid.
REQ-009 o_tx_data  out  8  byte to send; o_tx_start  out  1  one-cycle send pulse; i_tx_done  in  1  one-cycle strobe, byte sent.
REQ-010 o_prog_we  out  1, o_prog_addr  out  NB_ADDR, o_prog_data  out  NB_INSTRUC: program-memory write port.
REQ-011 i_instruc  in  NB_INSTRUC  instruction currently fetched by the CPU.
REQ-012 i_cpu_pc  in  NB_ADDR, i_cpu_acc  in  NB_DATA: CPU PC and accumulator.
REQ-013 o_cpu_en  out  1  CPU clock enable; o_cpu_rst_n  out  1  CPU reset, active-low.
REQ-014 o_state  out  3  current state: IDLE=0, LOAD_HI=1, LOAD_LO=2, CPU_RST=3, RUN=4, STEP=5, SEND=6.

Function
REQ-015 IDLE: on i_rx_valid, 0x4C ('L') -> LOAD_HI with load address 0; 0x52 ('R') -> CPU_RST; 0x53 ('S') -> STEP; any other byte is ignored.
REQ-016 LOAD_HI: on i_rx_valid, latch the byte as the high byte -> LOAD_LO.
REQ-017 LOAD_LO: on i_rx_valid, assert o_prog_we for exactly one cycle with o_prog_data={hi,lo} and o_prog_addr=load address, then increment the address.
REQ-018 After a LOAD_LO write: word opcode == 0 (HALT) or address == 2^NB_ADDR-1 -> IDLE, address wraps to 0; otherwise -> LOAD_HI.
REQ-019 CPU_RST: hold o_cpu_rst_n=0 for exactly one cycle, clear the 16-bit cycle counter, then -> RUN.
REQ-020 RUN: o_cpu_en=1 combinationally on each cycle where i_instruc[NB_INSTRUC-1 -: NB_OPCODE] != 0; the cycle counter increments on each enabled cycle and saturates at 0xFFFF.
REQ-021 RUN stop: on the first cycle with HALT opcode, or with i_rx_valid && i_rx_data==0x41 ('A'), o_cpu_en=0 that cycle; snapshot PC, ACC and counter; -> SEND.
REQ-022 RUN stop on simultaneous HALT and 'A': treated as a single stop, same behaviour as REQ-021.
REQ-023 RUN: received bytes other than 'A' are ignored.
REQ-024 STEP: o_cpu_en=1 for exactly one cycle, counter +1 (saturating, not cleared), snapshot taken on the following cycle, -> SEND.
REQ-025 SEND: transmit 6 bytes in order PC_hi (zero-extended to 16 bits), PC_lo, ACC_hi, ACC_lo, CNT_hi, CNT_lo.
REQ-026 SEND handshake: o_tx_start pulses one cycle with o_tx_data stable; the next byte only after i_tx_done; after the 6th i_tx_done -> IDLE.
REQ-027 SEND: received bytes are ignored.
REQ-028 o_cpu_en SHALL be 0 in IDLE, LOAD_HI, LOAD_LO, CPU_RST and SEND.
REQ-029 o_prog_we SHALL be 0 outside LOAD_LO write cycles.
REQ-030 o_cpu_rst_n SHALL be 1 except during CPU_RST and while i_rst=0.

Reset
REQ-031 While i_rst=0: state IDLE, o_cpu_rst_n=0, o_cpu_en=0, o_prog_we=0, o_tx_start=0, o_tx_data=0, o_prog_addr=0, o_prog_data=0, counter=0, snapshot=0, o_state=0.
REQ-032 Reset asserted mid-load, mid-run or mid-send SHALL abort immediately: no further write pulse or tx pulse.

Verification
REQ-033 Reset: i_rst=0 for 3 cycles at any state -> all outputs per REQ-031; release -> o_state=0, o_cpu_rst_n=1.
REQ-034 Load: bytes 4C,08,05,00,00 -> writes addr0=0x0805, addr1=0x0000, exactly 2 o_prog_we pulses, then o_state=0.
REQ-035 Load wrap: 'L' then 2048 non-HALT words -> last write at addr 0x7FF, o_state=0; a new 'L' word lands at addr 0.
REQ-036 Run: 'R' with i_instruc non-HALT for 3 enabled cycles then HALT, PC=0x003, ACC=0x1234 -> tx 00,03,12,34,00,03; o_cpu_rst_n low exactly 1 cycle.
REQ-037 Abort: 'R' with a never-halting program, 'A' after 10 enabled cycles -> o_cpu_en=0 that cycle, CNT bytes 00,0A.
REQ-038 Step and tx: two 'S' commands after REQ-036 -> CNT reports 00,04 then 00,05; withholding i_tx_done stalls SEND with no extra o_tx_start.
